// File: rtl/game_ctrl.sv
// game_ctrl: game-flow controller upstream of the vertical scroll stage.
// Synchronises and debounces the player button, runs the IDLE/PLAY/DEAD
// state machine, drives the scroll stage's move/reset inputs, latches the
// final score and keeps a session high score.
// Optional feature: define GAME_CTRL_AUTOSTART_EN to leave IDLE automatically
// once the button has stayed released for DEBOUNCE_CYCLES clocks.
module game_ctrl #(
    parameter int DEBOUNCE_CYCLES  = 250000,
    parameter int DEAD_HOLD_CYCLES = 25000000,
    parameter int BLINK_CYCLES     = 6250000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_raw,
    input  logic       collision,
    input  logic [7:0] score,
    output logic       move_btn,
    output logic       scroll_rst,
    output logic [1:0] game_state,
    output logic [7:0] final_score,
    output logic [7:0] high_score,
    output logic       blink
);

    // Counter widths: debounce and blink count to N-1, hold saturates at N.
    localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W  = (DEAD_HOLD_CYCLES > 0) ? $clog2(DEAD_HOLD_CYCLES + 1) : 1;
    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(DEAD_HOLD_CYCLES);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    state_t             state;
    logic               btn_meta;
    logic               btn_s;
    logic               btn_db;
    logic               btn_db_q;
    logic               btn_rise;
    logic [DB_W-1:0]    db_cnt;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [BLINK_W-1:0] blink_cnt;

    // Unsigned 8-bit maximum; ties keep the current value.
    function automatic logic [7:0] max_u8(input logic [7:0] cur, input logic [7:0] cand);
        return (cand > cur) ? cand : cur;
    endfunction

    // Two-flop synchroniser for the asynchronous button.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
        end else begin
            btn_meta <= btn_raw;
            btn_s    <= btn_meta;
        end
    end

    // Debouncer: flip btn_db only after DEBOUNCE_CYCLES consecutive disagreeing clocks.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_db <= 1'b0;
            db_cnt <= '0;
        end else if (btn_s == btn_db) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            btn_db <= btn_s;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // Delayed debounced level for one-clock rising-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_db_q <= 1'b0;
        end else begin
            btn_db_q <= btn_db;
        end
    end

    assign btn_rise = btn_db & ~btn_db_q;

`ifdef GAME_CTRL_AUTOSTART_EN
    logic [DB_W-1:0] auto_cnt;
    logic            auto_go;

    // Counts consecutive released clocks since entering IDLE; any press restarts it.
    always_ff @(posedge clk) begin
        if (reset || (state != ST_IDLE) || btn_db || auto_go) begin
            auto_cnt <= '0;
        end else begin
            auto_cnt <= auto_cnt + 1'b1;
        end
    end

    assign auto_go = (state == ST_IDLE) && !btn_db && (auto_cnt == DB_LAST);
`endif

    // Game state machine with hold timer, blink generator and score latching.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            hold_cnt    <= '0;
            blink_cnt   <= '0;
            blink       <= 1'b0;
            final_score <= 8'd0;
            high_score  <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    hold_cnt  <= '0;
                    blink_cnt <= '0;
                    blink     <= 1'b0;
`ifdef GAME_CTRL_AUTOSTART_EN
                    if (btn_rise || auto_go) begin
                        state <= ST_PLAY;
                    end
`else
                    if (btn_rise) begin
                        state <= ST_PLAY;
                    end
`endif
                end
                ST_PLAY: begin
                    hold_cnt  <= '0;
                    blink_cnt <= '0;
                    blink     <= 1'b0;
                    // Collision takes priority over any button activity.
                    if (collision) begin
                        state       <= ST_DEAD;
                        final_score <= score;
                        high_score  <= max_u8(high_score, score);
                    end
                end
                ST_DEAD: begin
                    if (btn_rise && (hold_cnt == HOLD_MAX)) begin
                        state     <= ST_IDLE;
                        hold_cnt  <= '0;
                        blink_cnt <= '0;
                        blink     <= 1'b0;
                    end else begin
                        if (hold_cnt < HOLD_MAX) begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                        if (blink_cnt == BLINK_LAST) begin
                            blink     <= ~blink;
                            blink_cnt <= '0;
                        end else begin
                            blink_cnt <= blink_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign scroll_rst = (state == ST_IDLE);
    assign move_btn   = (state == ST_PLAY) && btn_db;
    assign game_state = state;

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed self-checking bench for game_ctrl with small
// debounce, hold and blink parameters so every phase fits in a few clocks.
module tb_game_ctrl;

    logic       clk;
    logic       reset;
    logic       btn_raw;
    logic       collision;
    logic [7:0] score;
    logic       move_btn;
    logic       scroll_rst;
    logic [1:0] game_state;
    logic [7:0] final_score;
    logic [7:0] high_score;
    logic       blink;

    int n_checks;
    int n_fail;

    game_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .DEAD_HOLD_CYCLES(8),
        .BLINK_CYCLES    (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .collision  (collision),
        .score      (score),
        .move_btn   (move_btn),
        .scroll_rst (scroll_rst),
        .game_state (game_state),
        .final_score(final_score),
        .high_score (high_score),
        .blink      (blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full press: button high 10 clks then low 8 clks. From IDLE, or from DEAD
    // with the hold expired, the state changes on the 7th clock.
    task automatic press_release();
        btn_raw = 1'b1;
        repeat (10) tick();
        btn_raw = 1'b0;
        repeat (8) tick();
    endtask

    task automatic collide(input logic [7:0] s);
        score     = s;
        collision = 1'b1;
        tick();
        collision = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_checks++; if (game_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", game_state); end
        n_checks++; if (scroll_rst !== 1'b1) begin n_fail++; $display("FAIL reset_scroll_rst: got %b expected 1", scroll_rst); end
        n_checks++; if (move_btn !== 1'b0) begin n_fail++; $display("FAIL reset_move_btn: got %b expected 0", move_btn); end
        n_checks++; if (final_score !== 8'd0) begin n_fail++; $display("FAIL reset_final: got %0d expected 0", final_score); end
        n_checks++; if (high_score !== 8'd0) begin n_fail++; $display("FAIL reset_high: got %0d expected 0", high_score); end
        n_checks++; if (blink !== 1'b0) begin n_fail++; $display("FAIL reset_blink: got %b expected 0", blink); end
    endtask

    task automatic test_glitch();
        btn_raw = 1'b1;
        repeat (3) tick();
        btn_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++; if (dut.btn_db !== 1'b0) begin n_fail++; $display("FAIL glitch_db cyc %0d: got %b expected 0", i, dut.btn_db); end
        end
        n_checks++; if (game_state !== 2'd0) begin n_fail++; $display("FAIL glitch_state: got %0d expected 0", game_state); end
    endtask

    task automatic test_start();
        btn_raw = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 5) begin
                n_checks++; if (dut.btn_db !== 1'b0) begin n_fail++; $display("FAIL start_db_early: got %b expected 0", dut.btn_db); end
            end
            if (i == 6) begin
                n_checks++; if (dut.btn_db !== 1'b1) begin n_fail++; $display("FAIL start_db_rise: got %b expected 1", dut.btn_db); end
                n_checks++; if (game_state !== 2'd0) begin n_fail++; $display("FAIL start_still_idle: got %0d expected 0", game_state); end
            end
            if (i == 7) begin
                n_checks++; if (game_state !== 2'd1) begin n_fail++; $display("FAIL start_play: got %0d expected 1", game_state); end
                n_checks++; if (scroll_rst !== 1'b0) begin n_fail++; $display("FAIL start_scroll_rst: got %b expected 0", scroll_rst); end
                n_checks++; if (move_btn !== 1'b1) begin n_fail++; $display("FAIL start_move: got %b expected 1", move_btn); end
            end
        end
        btn_raw = 1'b0;
        repeat (5) tick();
        n_checks++; if (move_btn !== 1'b1) begin n_fail++; $display("FAIL release_move_held: got %b expected 1", move_btn); end
        tick();
        n_checks++; if (move_btn !== 1'b0) begin n_fail++; $display("FAIL release_move_off: got %b expected 0", move_btn); end
        n_checks++; if (game_state !== 2'd1) begin n_fail++; $display("FAIL release_state: got %0d expected 1", game_state); end
        repeat (2) tick();
    endtask

    task automatic test_collision();
        collide(8'd20);
        n_checks++; if (final_score !== 8'd20) begin n_fail++; $display("FAIL first_final: got %0d expected 20", final_score); end
        n_checks++; if (high_score !== 8'd20) begin n_fail++; $display("FAIL first_high: got %0d expected 20", high_score); end
        repeat (10) tick();
        press_release();
        n_checks++; if (game_state !== 2'd0) begin n_fail++; $display("FAIL back_idle: got %0d expected 0", game_state); end
        collide(8'd99);
        n_checks++; if (game_state !== 2'd0) begin n_fail++; $display("FAIL idle_ignore_state: got %0d expected 0", game_state); end
        n_checks++; if (final_score !== 8'd20) begin n_fail++; $display("FAIL idle_ignore_final: got %0d expected 20", final_score); end
        press_release();
        n_checks++; if (game_state !== 2'd1) begin n_fail++; $display("FAIL replay: got %0d expected 1", game_state); end
        collide(8'd37);
        n_checks++; if (game_state !== 2'd2) begin n_fail++; $display("FAIL coll_state: got %0d expected 2", game_state); end
        n_checks++; if (final_score !== 8'd37) begin n_fail++; $display("FAIL coll_final: got %0d expected 37", final_score); end
        n_checks++; if (high_score !== 8'd37) begin n_fail++; $display("FAIL coll_high: got %0d expected 37", high_score); end
        n_checks++; if (move_btn !== 1'b0) begin n_fail++; $display("FAIL coll_move: got %b expected 0", move_btn); end
        n_checks++; if (scroll_rst !== 1'b0) begin n_fail++; $display("FAIL coll_scroll_rst: got %b expected 0", scroll_rst); end
    endtask

    task automatic test_lower_score();
        repeat (10) tick();
        press_release();
        press_release();
        collide(8'd12);
        n_checks++; if (final_score !== 8'd12) begin n_fail++; $display("FAIL lower_final: got %0d expected 12", final_score); end
        n_checks++; if (high_score !== 8'd37) begin n_fail++; $display("FAIL lower_high: got %0d expected 37", high_score); end
    endtask

    // Starts right after the DEAD entry edge; clocks below are counted from it.
    task automatic test_dead_hold();
        btn_raw = 1'b1;
        repeat (20) tick();
        n_checks++; if (game_state !== 2'd2) begin n_fail++; $display("FAIL hold_early_press: got %0d expected 2", game_state); end
        btn_raw = 1'b0;
        repeat (8) tick();
        n_checks++; if (game_state !== 2'd2) begin n_fail++; $display("FAIL hold_held_expiry: got %0d expected 2", game_state); end
        btn_raw = 1'b1;
        repeat (6) tick();
        n_checks++; if (game_state !== 2'd2) begin n_fail++; $display("FAIL hold_before_rise: got %0d expected 2", game_state); end
        n_checks++; if (blink !== 1'b0) begin n_fail++; $display("FAIL hold_blink_phase: got %b expected 0", blink); end
        tick();
        n_checks++; if (game_state !== 2'd0) begin n_fail++; $display("FAIL hold_exit: got %0d expected 0", game_state); end
        n_checks++; if (scroll_rst !== 1'b1) begin n_fail++; $display("FAIL hold_exit_scroll_rst: got %b expected 1", scroll_rst); end
        n_checks++; if (blink !== 1'b0) begin n_fail++; $display("FAIL hold_exit_blink: got %b expected 0", blink); end
        btn_raw = 1'b0;
        repeat (8) tick();
        n_checks++; if (game_state !== 2'd0) begin n_fail++; $display("FAIL hold_stay_idle: got %0d expected 0", game_state); end
    endtask

    task automatic test_blink();
        press_release();
        collide(8'd5);
        repeat (4) tick();
        n_checks++; if (blink !== 1'b0) begin n_fail++; $display("FAIL blink_c4: got %b expected 0", blink); end
        tick();
        n_checks++; if (blink !== 1'b1) begin n_fail++; $display("FAIL blink_c5: got %b expected 1", blink); end
        collide(8'd200);
        n_checks++; if (final_score !== 8'd5) begin n_fail++; $display("FAIL dead_ignore_final: got %0d expected 5", final_score); end
        n_checks++; if (game_state !== 2'd2) begin n_fail++; $display("FAIL dead_ignore_state: got %0d expected 2", game_state); end
        repeat (3) tick();
        n_checks++; if (blink !== 1'b1) begin n_fail++; $display("FAIL blink_c9: got %b expected 1", blink); end
        tick();
        n_checks++; if (blink !== 1'b0) begin n_fail++; $display("FAIL blink_c10: got %b expected 0", blink); end
    endtask

    task automatic test_midgame_reset();
        repeat (10) tick();
        press_release();
        btn_raw = 1'b1;
        repeat (7) tick();
        n_checks++; if (move_btn !== 1'b1) begin n_fail++; $display("FAIL mid_play_move: got %b expected 1", move_btn); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if (game_state !== 2'd0) begin n_fail++; $display("FAIL mid_reset_state: got %0d expected 0", game_state); end
        n_checks++; if (high_score !== 8'd0) begin n_fail++; $display("FAIL mid_reset_high: got %0d expected 0", high_score); end
        n_checks++; if (move_btn !== 1'b0) begin n_fail++; $display("FAIL mid_reset_move: got %b expected 0", move_btn); end
        n_checks++; if (blink !== 1'b0) begin n_fail++; $display("FAIL mid_reset_blink: got %b expected 0", blink); end
        btn_raw = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        btn_raw   = 1'b0;
        collision = 1'b0;
        score     = 8'd0;
        test_reset();
        test_glitch();
        test_start();
        test_collision();
        test_lower_score();
        test_dead_hold();
        test_blink();
        test_midgame_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Game-flow controller that sits directly upstream of the vertical scroll stage.
- Debounces the raw player button and runs the game state machine (IDLE / PLAY / DEAD).
- Drives the scroll stage's move_btn and reset inputs.
- Consumes the scroll stage's score to latch the final score and track a session high score for the display stage.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive clocks the synchronised button must differ from the debounced level before the debounced level flips (10 ms at 25 MHz).
- DEAD_HOLD_CYCLES, 25000000, minimum clocks spent in DEAD before a button press is accepted (1 s at 25 MHz).
- BLINK_CYCLES, 6250000, half-period of the game-over blink output.

Ports:
- clk  in  1  system clock, 25 MHz pixel clock.
- reset  in  1  synchronous, active-high; one clock; all state updates on posedge clk.
- btn_raw  in  1  asynchronous raw player button, active-high.
- collision  in  1  player/obstacle overlap flag from the collision stage, sampled each clk.
- score  in  8  live score from the scroll stage.
- move_btn  out  1  to scroll stage; high while in PLAY and debounced button held.
- scroll_rst  out  1  to scroll stage reset; high in IDLE.
- game_state  out  2  encoding: 0 = IDLE, 1 = PLAY, 2 = DEAD; 3 is never driven.
- final_score  out  8  score latched on entry to DEAD.
- high_score  out  8  session maximum of final_score.
- blink  out  1  toggles in DEAD for game-over flashing; 0 otherwise.

Behaviour:
- Synchroniser: btn_raw passes through 2 flops to give btn_s.
- Debouncer:
  - Counter clears whenever btn_s == btn_db; otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while btn_s != btn_db, btn_db flips and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never change btn_db.
- Edge detect: btn_rise = btn_db & ~btn_db_q (one clock wide).
- Reset values: state IDLE, btn_db 0, all counters 0, final_score 0, high_score 0, blink 0. Reset mid-game returns to IDLE on the next edge.
- Outputs are decoded from the state register, no added latency:
  - scroll_rst = (state == IDLE).
  - move_btn = (state == PLAY) & btn_db.
- IDLE:
  - On btn_rise → PLAY.
  - The press that starts the game also moves: btn_db is still high in the first PLAY cycle.
- PLAY:
  - collision == 1 → DEAD; on the same edge, final_score <= score and high_score <= max(high_score, score).
  - The comparison is unsigned 8-bit; equal scores leave high_score unchanged.
  - collision is ignored in IDLE and DEAD.
- DEAD:
  - move_btn = 0 and scroll_rst = 0, so the scroll stage freezes and holds its position and score.
  - Hold counter increments, saturating at DEAD_HOLD_CYCLES.
  - btn_rise while hold < DEAD_HOLD_CYCLES is discarded.
  - btn_rise once hold == DEAD_HOLD_CYCLES → IDLE; hold counter clears.
  - Blink counter toggles blink every BLINK_CYCLES clocks; blink is forced to 0 and its counter cleared on leaving DEAD.
- Simultaneous events:
  - collision and btn_rise in the same PLAY cycle: collision wins → DEAD.
  - A button held through DEAD expiry does not restart; a new rising edge is required.
- All counters are wide enough for their parameters: 18-bit debounce, 25-bit hold, 23-bit blink at defaults. Counters must never wrap.

Optional Feature:
- Macro GAME_CTRL_AUTOSTART_EN.
- Defined: IDLE exits to PLAY automatically once the button has been released (btn_db == 0) for DEBOUNCE_CYCLES consecutive clocks after entering IDLE. The first PLAY cycle has move_btn = 0. btn_rise in IDLE still enters PLAY immediately.
- Undefined: IDLE waits indefinitely for btn_rise as described above.

Test Plan:
- Reset and start: DEBOUNCE_CYCLES = 4; hold btn_raw = 1 for 10 clks → btn_db high 6 clks after btn_raw rises (2 sync + 4). Then game_state 0→1, scroll_rst 1→0, move_btn = 1.
- Glitch rejection: DEBOUNCE_CYCLES = 4, pulse btn_raw high for 3 clks in IDLE → btn_db stays 0, game_state stays 0.
- Collision latch: in PLAY with score = 37, high_score = 20, pulse collision 1 clk → next cycle game_state = 2, final_score = 37, high_score = 37, move_btn = 0.
- Lower score: then restart and die with score = 12 → final_score = 12, high_score stays 37.
- Dead hold: DEAD_HOLD_CYCLES = 8. Press at DEAD cycle 3 → ignored, still DEAD. Press after cycle 8 → game_state = 0, scroll_rst = 1.
- Blink and mid-game reset: BLINK_CYCLES = 5 → blink toggles every 5 clks in DEAD. Assert reset during PLAY → next clk game_state = 0, high_score = 0, move_btn = 0, blink = 0.
